// File: rtl/event_pkg.sv
// Shared event-path types: FSM state encoding, default field widths and
// the packed event record used by the deserialiser, this filter and the buffer.
package event_pkg;

   localparam int XW_DEF = 8;
   localparam int YW_DEF = 8;
   localparam int TW_DEF = 16;
   localparam int PW_DEF = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      EMIT  = 2'd2
   } state_t;

   typedef struct packed {
      logic [XW_DEF-1:0] x;
      logic [YW_DEF-1:0] y;
      logic [TW_DEF-1:0] t;
      logic [PW_DEF-1:0] p;
   } event_t;

endpackage

// File: rtl/event_persistence_filter_if.sv
// Valid/ready event stream bundle: input side from the deserialiser,
// output side towards the event buffer. slave = filter, master = its peers.
interface event_persistence_filter_if
   import event_pkg::*;
#(
   parameter int XW = XW_DEF,
   parameter int YW = YW_DEF,
   parameter int TW = TW_DEF,
   parameter int PW = PW_DEF
);
   logic          in_valid;
   logic          in_ready;
   logic [XW-1:0] in_x;
   logic [YW-1:0] in_y;
   logic [TW-1:0] in_t;
   logic [PW-1:0] in_p;

   logic          out_valid;
   logic          out_ready;
   logic [XW-1:0] out_x;
   logic [YW-1:0] out_y;
   logic [TW-1:0] out_t;
   logic [PW-1:0] out_p;

   modport slave (
      input  in_valid, in_x, in_y, in_t, in_p,
      output in_ready,
      output out_valid, out_x, out_y, out_t, out_p,
      input  out_ready
   );

   modport master (
      output in_valid, in_x, in_y, in_t, in_p,
      input  in_ready,
      input  out_valid, out_x, out_y, out_t, out_p,
      output out_ready
   );
endinterface

// File: rtl/event_window_cmp.sv
// Combinational match test of an incoming event against the held candidate:
// wrap-around time distance within the window, and equal polarity.
module event_window_cmp #(
   parameter int TW = 16,
   parameter int PW = 1
) (
   input  logic [TW-1:0] i_cand_t,
   input  logic [TW-1:0] i_in_t,
   input  logic [TW-1:0] i_window,
   input  logic [PW-1:0] i_cand_p,
   input  logic [PW-1:0] i_in_p,
   output logic          o_window_ok,
   output logic          o_pol_match
);
   logic [TW-1:0] w_dt;

   // Modulo 2^TW subtraction so a timestamp rollover still yields a small dt.
   assign w_dt        = i_in_t - i_cand_t;
   assign o_window_ok = (w_dt <= i_window);
   assign o_pol_match = (i_in_p == i_cand_p);
endmodule

// File: rtl/event_persistence_filter.sv
// DVS persistence filter: holds one candidate event and forwards it once
// cfg_count same-polarity events arrive within cfg_window ticks of it.
module event_persistence_filter
   import event_pkg::*;
#(
   parameter int XW  = XW_DEF,
   parameter int YW  = YW_DEF,
   parameter int TW  = TW_DEF,
   parameter int PW  = PW_DEF,
   parameter int CW  = 4,
   parameter int DCW = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   event_persistence_filter_if.slave bus,
   input  logic [CW-1:0]       cfg_count,
   input  logic [TW-1:0]       cfg_window,
   input  logic                cfg_bypass,
   output logic [DCW-1:0]      drop_count
);
   state_t         r_state;
   logic [XW-1:0]  r_cand_x, r_out_x;
   logic [YW-1:0]  r_cand_y, r_out_y;
   logic [TW-1:0]  r_cand_t, r_out_t;
   logic [PW-1:0]  r_cand_p, r_out_p;
   logic [CW-1:0]  r_cnt;
   logic [DCW-1:0] r_drop;
   logic           r_out_valid;

   logic           w_in_ready;
   logic           w_accept;
   logic           w_out_hs;
   logic           w_window_ok;
   logic           w_pol_match;
   logic [CW:0]    w_cnt_inc;
   logic           w_confirm_done;

   event_window_cmp #(
      .TW (TW),
      .PW (PW)
   ) u_cmp (
      .i_cand_t    (r_cand_t),
      .i_in_t      (bus.in_t),
      .i_window    (cfg_window),
      .i_cand_p    (r_cand_p),
      .i_in_p      (bus.in_p),
      .o_window_ok (w_window_ok),
      .o_pol_match (w_pol_match)
   );

   // Ready depends only on state and bypass so upstream never sees a loop through in_valid.
   assign w_in_ready     = (r_state == IDLE) || ((r_state == ARMED) && !cfg_bypass);
   assign w_accept       = bus.in_valid && w_in_ready;
   assign w_out_hs       = r_out_valid && bus.out_ready;
   // One extra bit keeps the increment from wrapping if the threshold is raised mid-run.
   assign w_cnt_inc      = {1'b0, r_cnt} + (CW+1)'(1);
   assign w_confirm_done = (w_cnt_inc >= {1'b0, cfg_count});

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_x     = r_out_x;
   assign bus.out_y     = r_out_y;
   assign bus.out_t     = r_out_t;
   assign bus.out_p     = r_out_p;
   assign drop_count    = r_drop;

   // Filter FSM with candidate, confirm counter, drop counter and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cand_x    <= '0;
         r_cand_y    <= '0;
         r_cand_t    <= '0;
         r_cand_p    <= '0;
         r_out_x     <= '0;
         r_out_y     <= '0;
         r_out_t     <= '0;
         r_out_p     <= '0;
         r_out_valid <= 1'b0;
         r_cnt       <= '0;
         r_drop      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_cand_x <= bus.in_x;
                  r_cand_y <= bus.in_y;
                  r_cand_t <= bus.in_t;
                  r_cand_p <= bus.in_p;
                  r_cnt    <= '0;
                  if (cfg_bypass || (cfg_count == '0)) begin
                     r_out_x     <= bus.in_x;
                     r_out_y     <= bus.in_y;
                     r_out_t     <= bus.in_t;
                     r_out_p     <= bus.in_p;
                     r_out_valid <= 1'b1;
                     r_state     <= EMIT;
                  end else begin
                     r_state <= ARMED;
                  end
               end
            end
            ARMED: begin
               if (cfg_bypass) begin
                  r_out_x     <= r_cand_x;
                  r_out_y     <= r_cand_y;
                  r_out_t     <= r_cand_t;
                  r_out_p     <= r_cand_p;
                  r_out_valid <= 1'b1;
                  r_state     <= EMIT;
               end else if (w_accept) begin
                  if (!w_window_ok || !w_pol_match) begin
                     if (r_drop != '1) begin
                        r_drop <= r_drop + DCW'(1);
                     end
                     r_cand_x <= bus.in_x;
                     r_cand_y <= bus.in_y;
                     r_cand_t <= bus.in_t;
                     r_cand_p <= bus.in_p;
                     r_cnt    <= '0;
                  end else begin
                     r_cnt <= w_cnt_inc[CW-1:0];
                     if (w_confirm_done) begin
                        r_out_x     <= r_cand_x;
                        r_out_y     <= r_cand_y;
                        r_out_t     <= r_cand_t;
                        r_out_p     <= r_cand_p;
                        r_out_valid <= 1'b1;
                        r_state     <= EMIT;
                     end
                  end
               end
            end
            EMIT: begin
               if (w_out_hs) begin
                  r_out_valid <= 1'b0;
                  r_cnt       <= '0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end
endmodule
